// File: rtl/tilt_seq_pkg.sv
// rtl/tilt_seq_pkg.sv - shared widths, defaults and FSM encoding for the tilt sequencer
package tilt_pkg;

  localparam int CRD_W         = 24;
  localparam int ACC_W         = 16;
  localparam int MAG_SCALE_DEF = 19898;

  typedef enum logic [2:0] {
    IDLE,
    ROLL_REQ,
    ROLL_WAIT,
    MAG,
    PITCH_REQ,
    PITCH_WAIT,
    OUT
  } state_t;

  function automatic logic signed [CRD_W-1:0] sext_acc(input logic signed [ACC_W-1:0] v);
    return {{(CRD_W-ACC_W){v[ACC_W-1]}}, v};
  endfunction

endpackage

// File: rtl/tilt_seq_if.sv
// rtl/tilt_seq_if.sv - CORDIC start/done operand and result bus
interface tilt_seq_if import tilt_pkg::*; ();

  logic signed [CRD_W-1:0] crd_x;
  logic signed [CRD_W-1:0] crd_y;
  logic                    crd_start;
  logic                    crd_done;
  logic signed [CRD_W-1:0] crd_angle;
  logic signed [CRD_W-1:0] crd_magnitude;

  modport master (
    output crd_x, crd_y, crd_start,
    input  crd_done, crd_angle, crd_magnitude
  );

  modport slave (
    input  crd_x, crd_y, crd_start,
    output crd_done, crd_angle, crd_magnitude
  );

endinterface

// File: rtl/mag_comp.sv
// rtl/mag_comp.sv - registered signed x unsigned Q1.15 CORDIC gain compensation
module mag_comp import tilt_pkg::*; #(
  parameter int SCALE = MAG_SCALE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [CRD_W-1:0] m,
  output logic signed [CRD_W-1:0] mc
);

  localparam logic signed [16:0] SCALE_S = 17'(SCALE);

  logic signed [CRD_W+16:0] prod;

  assign prod = m * SCALE_S;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc <= '0;
    end else if (en) begin
      mc <= CRD_W'(prod >>> 15);
    end
  end

endmodule

// File: rtl/tilt_seq.sv
// rtl/tilt_seq.sv - two-pass CORDIC sequencer turning accelerometer samples into roll/pitch
module tilt_seq import tilt_pkg::*; #(
  parameter int MAG_SCALE   = MAG_SCALE_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic signed [ACC_W-1:0] acc_x,
  input  logic signed [ACC_W-1:0] acc_y,
  input  logic signed [ACC_W-1:0] acc_z,
  tilt_seq_if.master              crd,
  output logic signed [CRD_W-1:0] roll,
  output logic signed [CRD_W-1:0] pitch,
  output logic                    tilt_valid,
  output logic                    tilt_err
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t                  state, state_nx;
  logic                    done_q;
  logic                    done_edge;
  logic                    in_wait;
  logic                    expired;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] ax_r;
  logic signed [CRD_W-1:0] roll_n;
  logic signed [CRD_W-1:0] m_r;
  logic signed [CRD_W-1:0] mc;
  logic signed [CRD_W-1:0] crd_x_r;
  logic signed [CRD_W-1:0] crd_y_r;
  logic                    sel_pitch;

  assign done_edge = crd.crd_done & ~done_q;
  assign in_wait   = (state == ROLL_WAIT) || (state == PITCH_WAIT);
  assign expired   = (cnt == LAST) && !done_edge;

  // Pass-2 x operand comes straight from the scaler register, which holds until the next MAG.
  assign crd.crd_x = sel_pitch ? mc : crd_x_r;
  assign crd.crd_y = crd_y_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    acc_ready     = 1'b0;
    crd.crd_start = 1'b0;
    tilt_valid    = 1'b0;
    case (state)
      IDLE: begin
        acc_ready = 1'b1;
        if (acc_valid) state_nx = ROLL_REQ;
      end
      ROLL_REQ: begin
        crd.crd_start = 1'b1;
        state_nx      = ROLL_WAIT;
      end
      ROLL_WAIT: begin
        if (done_edge)    state_nx = MAG;
        else if (expired) state_nx = IDLE;
      end
      MAG: state_nx = PITCH_REQ;
      PITCH_REQ: begin
        crd.crd_start = 1'b1;
        state_nx      = PITCH_WAIT;
      end
      PITCH_WAIT: begin
        if (done_edge)    state_nx = OUT;
        else if (expired) state_nx = IDLE;
      end
      OUT: begin
        tilt_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      cnt       <= '0;
      tilt_err  <= 1'b0;
      ax_r      <= '0;
      roll_n    <= '0;
      m_r       <= '0;
      crd_x_r   <= '0;
      crd_y_r   <= '0;
      sel_pitch <= 1'b0;
      roll      <= '0;
      pitch     <= '0;
    end else begin
      done_q   <= crd.crd_done;
      tilt_err <= in_wait && expired;
      if (crd.crd_start) cnt <= '0;
      else if (in_wait)  cnt <= cnt + CNT_W'(1);
      case (state)
        IDLE: if (acc_valid) begin
          ax_r      <= acc_x;
          crd_x_r   <= sext_acc(acc_z);
          crd_y_r   <= sext_acc(acc_y);
          sel_pitch <= 1'b0;
        end
        ROLL_WAIT: if (done_edge) begin
          roll_n <= crd.crd_angle;
          m_r    <= crd.crd_magnitude;
        end
        MAG: begin
          crd_y_r   <= -sext_acc(ax_r);
          sel_pitch <= 1'b1;
        end
        PITCH_WAIT: if (done_edge) begin
          roll  <= roll_n;
          pitch <= crd.crd_angle;
        end
        default: ;
      endcase
    end
  end

  mag_comp #(.SCALE(MAG_SCALE)) u_mag_comp (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == MAG),
    .m     (m_r),
    .mc    (mc)
  );

endmodule

// File: tb/tb_tilt_seq.sv
// tb/tb_tilt_seq.sv - directed self-checking bench for tilt_seq with a programmable CORDIC stub
module tb_tilt_seq;
  import tilt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic acc_valid = 1'b0;
  logic signed [15:0] acc_x = '0, acc_y = '0, acc_z = '0;
  logic acc_ready, tilt_valid, tilt_err;
  logic signed [23:0] roll, pitch;

  tilt_seq_if crd_bus();

  int checks = 0;
  int errors = 0;

  int cfg_lc = 16;
  logic cfg_en = 1'b1;
  logic cfg_hold = 1'b0;
  logic signed [23:0] cfg_a1 = '0, cfg_a2 = '0, cfg_mag = '0;

  logic stub_done = 1'b0;
  logic stub_busy = 1'b0;
  logic stub_pass = 1'b0;
  logic stub_cur = 1'b0;
  int   stub_cnt = 0;
  logic signed [23:0] stub_angle = '0, stub_mag = '0;
  logic signed [23:0] log_x [2];
  logic signed [23:0] log_y [2];

  assign crd_bus.crd_done      = stub_done;
  assign crd_bus.crd_angle     = stub_angle;
  assign crd_bus.crd_magnitude = stub_mag;

  tilt_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_x      (acc_x),
    .acc_y      (acc_y),
    .acc_z      (acc_z),
    .crd        (crd_bus),
    .roll       (roll),
    .pitch      (pitch),
    .tilt_valid (tilt_valid),
    .tilt_err   (tilt_err)
  );

  always #5 clk = ~clk;

  // Stub: done rises Lc cycles after the start cycle; the line is pulled low one cycle before
  // so a level held over from the previous pass still produces a fresh 0->1 edge.
  always @(posedge clk) begin
    if (acc_valid && acc_ready) stub_pass <= 1'b0;
    if (crd_bus.crd_start) begin
      stub_cur          <= stub_pass;
      stub_pass         <= 1'b1;
      log_x[stub_pass]  <= crd_bus.crd_x;
      log_y[stub_pass]  <= crd_bus.crd_y;
      stub_cnt          <= 1;
      stub_busy         <= 1'b1;
      if (!cfg_hold) stub_done <= 1'b0;
    end else if (stub_busy) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == cfg_lc - 2) stub_done <= 1'b0;
      if (stub_cnt == cfg_lc - 1) begin
        stub_busy <= 1'b0;
        if (cfg_en) begin
          stub_done  <= 1'b1;
          stub_angle <= stub_cur ? cfg_a2 : cfg_a1;
          stub_mag   <= cfg_mag;
        end
      end
    end
  end

  typedef struct {
    int ax, ay, az, lc, a1, mag, a2;
    int x1, y1, x2, y2, lat;
  } vec_t;

  vec_t vecs [4];
  vec_t hv;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int k;
    cfg_lc  = v.lc;
    cfg_a1  = 24'(v.a1);
    cfg_a2  = 24'(v.a2);
    cfg_mag = 24'(v.mag);
    acc_x = 16'(v.ax);
    acc_y = 16'(v.ay);
    acc_z = 16'(v.az);
    acc_valid = 1'b1;
    check({tag, "_ready_idle"}, 32'(acc_ready), 1);
    step();
    acc_valid = 1'b0;
    k = 1;
    while (!tilt_valid && k < 400) begin
      step();
      k++;
    end
    check({tag, "_latency"}, k, v.lat);
    check({tag, "_roll"}, roll, v.a1);
    check({tag, "_pitch"}, pitch, v.a2);
    check({tag, "_x1"}, log_x[0], v.x1);
    check({tag, "_y1"}, log_y[0], v.y1);
    check({tag, "_x2"}, log_x[1], v.x2);
    check({tag, "_y2"}, log_y[1], v.y2);
    step();
    check({tag, "_valid_pulse"}, 32'(tilt_valid), 0);
    check({tag, "_ready_back"}, 32'(acc_ready), 1);
  endtask

  initial begin
    int k;
    int tv_seen;
    int ready_bad;

    vecs[0] = '{ax:-100,   ay:5,      az:16384,  lc:16, a1:1000,   mag:32768,  a2:2000,
                x1:16384,  y1:5,      x2:19898,  y2:100,    lat:36};
    vecs[1] = '{ax:-32768, ay:-32768, az:-32768, lc:4,  a1:-500,   mag:46341,  a2:-7000,
                x1:-32768, y1:-32768, x2:28140,  y2:32768,  lat:12};
    vecs[2] = '{ax:1234,   ay:-1,     az:0,      lc:3,  a1:123456, mag:131072, a2:-100000,
                x1:0,      y1:-1,     x2:79592,  y2:-1234,  lat:10};
    vecs[3] = '{ax:0,      ay:7,      az:-9,     lc:5,  a1:7,      mag:-3,     a2:0,
                x1:-9,     y1:7,      x2:-2,     y2:0,      lat:14};
    hv      = '{ax:-100,   ay:5,      az:16384,  lc:16, a1:4444,   mag:32768,  a2:5555,
                x1:16384,  y1:5,      x2:19898,  y2:100,    lat:36};

    step();
    step();
    check("rst_acc_ready", 32'(acc_ready), 1);
    check("rst_crd_start", 32'(crd_bus.crd_start), 0);
    check("rst_tilt_valid", 32'(tilt_valid), 0);
    check("rst_tilt_err", 32'(tilt_err), 0);
    check("rst_roll", roll, 0);
    check("rst_pitch", pitch, 0);
    check("rst_crd_x", crd_bus.crd_x, 0);
    check("rst_crd_y", crd_bus.crd_y, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Done still high from the previous operation.
    check("stale_done_level", 32'(stub_done), 1);
    cfg_hold = 1'b1;
    run_vec(hv, "stale");
    cfg_hold = 1'b0;

    // Lost done.
    cfg_en = 1'b0;
    acc_x = 16'sd1; acc_y = 16'sd2; acc_z = 16'sd3;
    acc_valid = 1'b1;
    step();
    acc_valid = 1'b0;
    k = 1;
    tv_seen = 0;
    while (!tilt_err && k < 400) begin
      if (tilt_valid) tv_seen++;
      step();
      k++;
    end
    check("timeout_cycle", k, 257);
    check("timeout_roll_hold", roll, 4444);
    check("timeout_pitch_hold", pitch, 5555);
    check("timeout_ready", 32'(acc_ready), 1);
    step();
    check("timeout_err_pulse", 32'(tilt_err), 0);
    check("timeout_ready_next", 32'(acc_ready), 1);
    check("timeout_no_valid", tv_seen, 0);
    cfg_en = 1'b1;

    // Reset during PITCH_WAIT.
    cfg_lc = 20; cfg_a1 = 24'sd9; cfg_a2 = 24'sd10; cfg_mag = 24'sd32768;
    acc_x = -16'sd100; acc_y = 16'sd5; acc_z = 16'sd16384;
    acc_valid = 1'b1;
    step();
    acc_valid = 1'b0;
    for (int i = 1; i < 30; i++) step();
    check("prerst_busy", 32'(acc_ready), 0);
    check("prerst_crd_x", crd_bus.crd_x, 19898);
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc_ready", 32'(acc_ready), 1);
    check("arst_crd_x", crd_bus.crd_x, 0);
    check("arst_crd_y", crd_bus.crd_y, 0);
    check("arst_roll", roll, 0);
    check("arst_pitch", pitch, 0);
    check("arst_crd_start", 32'(crd_bus.crd_start), 0);
    step();
    step();
    rst_n = 1'b1;
    tv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tilt_valid || tilt_err) tv_seen++;
    end
    check("arst_late_done_ignored", tv_seen, 0);
    check("arst_roll_still0", roll, 0);
    run_vec(vecs[0], "post_rst");

    // acc_valid held high: one sample per IDLE visit.
    cfg_lc = 4; cfg_a1 = 24'sd111; cfg_a2 = 24'sd222; cfg_mag = 24'sd32768;
    acc_valid = 1'b1;
    ready_bad = 0;
    tv_seen = 0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) step();
      check($sformatf("cont_idle%0d", s), 32'(acc_ready), 1);
      for (int j = 1; j <= 12; j++) begin
        step();
        if (acc_ready) ready_bad++;
        if (tilt_valid) begin
          tv_seen++;
          if (j != 12) ready_bad++;
        end
      end
    end
    acc_valid = 1'b0;
    check("cont_ready_low", ready_bad, 0);
    check("cont_valid_count", tv_seen, 3);
    check("cont_roll", roll, 111);
    check("cont_pitch", pitch, 222);
    step();
    step();
    check("cont_stays_idle", 32'(acc_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tilt_seq.md
# tilt_seq

Accelerometer-to-tilt sequencer that feeds the shared `cordic` vectoring core. Per accepted sample it runs two CORDIC passes:
- roll = atan2(ay, az), which also yields m = |(ay, az)|;
- pitch = atan2(−ax, m·K⁻¹).

It holds the latest roll/pitch for the attitude controller. It owns the CORDIC start/done handshake, including gain compensation of the intermediate magnitude and a lost-done timeout.

## Interface
Parameters:
- `MAG_SCALE`, 19898: CORDIC gain compensation, unsigned Q1.15 (≈0.60725·2¹⁵).
- `TIMEOUT_CYC`, 255: maximum number of WAIT cycles without a crd_done rising edge.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `acc_valid` in 1: accelerometer sample valid.
- `acc_ready` out 1: sample accepted when acc_valid && acc_ready.
- `acc_x`, `acc_y`, `acc_z` in 16 each, signed: accelerometer axes.
- `crd_x`, `crd_y` out 24 each, signed: CORDIC operands.
- `crd_start` out 1: one-cycle CORDIC start pulse.
- `crd_done` in 1: CORDIC done (level).
- `crd_angle`, `crd_magnitude` in 24 each, signed: CORDIC results.
- `roll`, `pitch` out 24, signed: latest tilt, in crd_angle units, passed through unchanged.
- `tilt_valid` out 1: one-cycle pulse when roll/pitch update.
- `tilt_err` out 1: one-cycle pulse on timeout.

## Operation
State machine:
- IDLE: acc_ready = 1 only in this state. On acceptance, register ax/ay/az and go to ROLL_REQ.
- ROLL_REQ: crd_x = sext(az), crd_y = sext(ay), crd_start = 1. Next state is ROLL_WAIT.
- ROLL_WAIT: on a crd_done rising edge, capture roll_n = crd_angle and m = crd_magnitude, then go to MAG.
- MAG: mc = (m · MAG_SCALE) >>> 15.
  - The product is 40-bit signed; truncate to 24 bits.
  - |m| ≤ 2¹⁷, so no overflow occurs.
  - Next state is PITCH_REQ.
- PITCH_REQ: crd_x = mc, crd_y = −sext(ax), crd_start = 1. Next state is PITCH_WAIT.
  - Negation is done after sign-extension to 24 bits, so ax = −32768 gives +32768 with no wrap.
- PITCH_WAIT: on a crd_done rising edge, capture pitch_n and go to OUT.
- OUT: roll ← roll_n, pitch ← pitch_n, tilt_valid = 1. Next state is IDLE.

Handshake and timeout rules:
- crd_done is edge-qualified: done_edge = crd_done & ~crd_done_q. A level held over from the previous operation is never captured.
- crd_x and crd_y hold stable from the REQ cycle until the next REQ.
- Timeout:
  - A counter clears on entry to either WAIT state.
  - When it reaches TIMEOUT_CYC with no done_edge: go to IDLE, pulse tilt_err, and leave roll/pitch unchanged.
- acc_valid outside IDLE is ignored; there is no queuing.

Reset (asynchronous assert):
- State is IDLE.
- roll, pitch, crd_x, crd_y and the captured registers are 0.
- crd_start, tilt_valid and tilt_err are 0.
- crd_done_q is 0.
- acc_ready is 1.

Reset asserted mid-operation aborts the operation with no tilt_valid. A done edge arriving later is ignored because the state is IDLE.

## Timing
- Acceptance edge E0; ROLL_REQ is cycle 1.
- Lc = cycles from a crd_start cycle to the first cycle with crd_done high.
- roll captured at the end of cycle 1+Lc1; MAG is cycle 2+Lc1; PITCH_REQ is cycle 3+Lc1.
- tilt_valid is high in cycle 4+Lc1+Lc2 after E0. acc_ready returns the next cycle.
- Minimum back-to-back sample period: Lc1+Lc2+5 cycles.
- tilt_err is high in the cycle after the TIMEOUT_CYC-th WAIT cycle.

## Structure
- Shared package `tilt_pkg`:
  - state encoding (IDLE, ROLL_REQ, ROLL_WAIT, MAG, PITCH_REQ, PITCH_WAIT, OUT);
  - CRD_W = 24;
  - default MAG_SCALE;
  - ACC_W = 16.
- Sub-module `mag_comp`: the one-cycle registered signed×unsigned Q1.15 scaler used in MAG.
- The top level contains the FSM, the edge detect and the timeout counter. No other sub-modules.

## Test plan
The bench uses a stub CORDIC returning programmed angle/magnitude with programmable Lc, plus a sanity run against the real `cordic`.

1. Nominal path:
   - Stimulus: Lc = 16, pass-1 stub returns angle 1000 / magnitude 32768, pass-2 returns angle 2000; sample ax = −100, ay = 5, az = 16384.
   - Pass 1 operands: crd_x = 16384, crd_y = 5.
   - Pass 2 operands: crd_x = 19898, crd_y = 100.
   - Result: roll = 1000, pitch = 2000, tilt_valid in cycle 36 after E0.
2. ax = −32768 → pass-2 crd_y = 32768 (24'h008000); ay = az = −32768 sign-extend correctly.
3. Stub never raises done:
   - tilt_err pulses after 255 ROLL_WAIT cycles;
   - roll/pitch hold their previous values;
   - acc_ready = 1 the next cycle.
4. Stale done: stub keeps crd_done high from the previous op into ROLL_WAIT → no capture until the next 0→1 edge, and results are correct.
5. rst_n low during PITCH_WAIT:
   - all outputs return to reset values immediately (asynchronously);
   - a later stub done is ignored;
   - the next sample completes normally.
6. acc_valid held high continuously:
   - only IDLE-cycle samples are accepted;
   - acc_ready = 0 from ROLL_REQ through OUT;
   - exactly one tilt_valid per accepted sample.
